// File: rtl/waterfall_scroller.sv
// Scrolling frame-buffer controller for the LCD waterfall display.
// Produces the frame-buffer read address for video readout. Every
// scroll_div+1 frames it copies one row of bins from the freq BRAM into the
// frame buffer during vertical blanking. It also clears the whole buffer
// after reset or on request.
//
// Bin read contract: the freq BRAM has a fixed one-cycle read latency and no
// handshake. While o_bin_rd_en is high, i_bin_rd_data in the following cycle
// holds the bin at the o_bin_rd_addr of the current cycle. Each frame-buffer
// write therefore trails its bin read by exactly one cycle. o_fb_wdata
// passes that data straight through during row writes.
module waterfall_scroller #(
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int FB_ADDR_W = 17,
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [X_W-1:0]       i_x,
    input  logic [Y_W-1:0]       i_y,
    input  logic                 i_lower_blank,
    input  logic [DIV_W-1:0]     i_scroll_div,
    input  logic                 i_scroll_dir,
    input  logic                 i_pause,
    input  logic                 i_clear_req,
    output logic                 o_bin_rd_en,
    output logic [X_W-1:0]       o_bin_rd_addr,
    input  logic [DATA_W-1:0]    i_bin_rd_data,
    output logic [FB_ADDR_W-1:0] o_fb_addr,
    output logic [DATA_W-1:0]    o_fb_wdata,
    output logic                 o_fb_we,
    output logic [Y_W-1:0]       o_top_row,
    output logic                 o_busy,
    output logic                 o_row_done,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_CLEAR      = 2'd0,
        S_VIDEO      = 2'd1,
        S_WRITE_ROW  = 2'd2,
        S_WAIT_VIDEO = 2'd3
    } state_t;

    localparam int CNT_W = X_W + 1;
    localparam int SUM_W = Y_W + 1;
    localparam logic [FB_ADDR_W-1:0] FB_END   = FB_ADDR_W'(H_RES * V_RES);
    localparam logic [FB_ADDR_W-1:0] FB_H     = FB_ADDR_W'(H_RES);
    localparam logic [FB_ADDR_W-1:0] FB_ONE   = FB_ADDR_W'(1);
    localparam logic [CNT_W-1:0]     COL_H    = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0]     COL_END  = CNT_W'(H_RES + 1);
    localparam logic [CNT_W-1:0]     COL_ONE  = CNT_W'(1);
    localparam logic [SUM_W-1:0]     SUM_V    = SUM_W'(V_RES);
    localparam logic [Y_W-1:0]       ROW_LAST = Y_W'(V_RES - 1);
    localparam logic [Y_W-1:0]       ROW_ONE  = Y_W'(1);
    localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);

    state_t                 r_state;
    state_t                 w_next;
    logic [FB_ADDR_W-1:0]   r_clr_addr;
    logic [CNT_W-1:0]       r_col;
    logic [Y_W-1:0]         r_top_row;
    logic [Y_W-1:0]         r_wr_row;
    logic [DIV_W-1:0]       r_frame_cnt;
    logic                   r_clear_pending;
    logic                   r_dir;
    logic                   r_fb_we;
    logic                   r_row_wr;
    logic [FB_ADDR_W-1:0]   r_fb_addr;
    logic                   r_bin_rd_en;
    logic [X_W-1:0]         r_bin_rd_addr;
    logic                   r_row_done;

    logic [SUM_W-1:0]       w_sum;
    logic [SUM_W-1:0]       w_wrapped;
    logic [FB_ADDR_W-1:0]   w_vid_addr;
    logic [CNT_W-1:0]       w_col_m1;
    logic [FB_ADDR_W-1:0]   w_wr_addr;
    logic [Y_W-1:0]         w_prev_row;
    logic [Y_W-1:0]         w_next_top;

    // y + top_row is always below 2*V_RES, so one conditional subtract wraps it.
    assign w_sum      = {1'b0, i_y} + {1'b0, r_top_row};
    assign w_wrapped  = (w_sum >= SUM_V) ? (w_sum - SUM_V) : w_sum;
    assign w_vid_addr = FB_ADDR_W'(w_wrapped[Y_W-1:0]) * FB_H + FB_ADDR_W'(i_x);

    // The write in progress is for the column read one cycle earlier.
    assign w_col_m1   = r_col - COL_ONE;
    assign w_wr_addr  = FB_ADDR_W'(r_wr_row) * FB_H + FB_ADDR_W'(w_col_m1);

    assign w_prev_row = (r_top_row == '0) ? ROW_LAST : (r_top_row - ROW_ONE);
    assign w_next_top = r_dir ? r_wr_row
                              : ((r_top_row == ROW_LAST) ? '0 : (r_top_row + ROW_ONE));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. CLEAR and WRITE_ROW run one extra cycle so that busy
    // stays high for the whole time their registered writes are visible.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_addr == FB_END) w_next = S_VIDEO;
            end
            S_VIDEO: begin
                if (i_lower_blank) begin
                    if (r_clear_pending)                 w_next = S_CLEAR;
                    else if (i_pause)                    w_next = S_WAIT_VIDEO;
                    else if (r_frame_cnt == i_scroll_div) w_next = S_WRITE_ROW;
                    else                                 w_next = S_WAIT_VIDEO;
                end
            end
            S_WRITE_ROW: begin
                if (r_col == COL_END) w_next = S_WAIT_VIDEO;
            end
            S_WAIT_VIDEO: begin
                if (!i_lower_blank) w_next = S_VIDEO;
            end
            default: w_next = S_CLEAR;
        endcase
    end

    // Datapath: clear sweep, scroll bookkeeping, row copy and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clr_addr      <= '0;
            r_col           <= '0;
            r_top_row       <= '0;
            r_wr_row        <= '0;
            r_frame_cnt     <= '0;
            r_clear_pending <= 1'b0;
            r_dir           <= 1'b0;
            r_fb_we         <= 1'b0;
            r_row_wr        <= 1'b0;
            r_fb_addr       <= '0;
            r_bin_rd_en     <= 1'b0;
            r_bin_rd_addr   <= '0;
            r_row_done      <= 1'b0;
        end else begin
            r_fb_we       <= 1'b0;
            r_row_wr      <= 1'b0;
            r_bin_rd_en   <= 1'b0;
            r_bin_rd_addr <= '0;
            r_row_done    <= 1'b0;
            r_fb_addr     <= w_vid_addr;
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_addr != FB_END) begin
                        r_fb_we    <= 1'b1;
                        r_fb_addr  <= r_clr_addr;
                        r_clr_addr <= r_clr_addr + FB_ONE;
                    end else begin
                        r_top_row <= '0;
                    end
                end
                S_VIDEO: begin
                    if (i_lower_blank) begin
                        if (r_clear_pending) begin
                            r_clr_addr      <= '0;
                            r_clear_pending <= 1'b0;
                        end else if (!i_pause) begin
                            if (r_frame_cnt == i_scroll_div) begin
                                r_frame_cnt <= '0;
                                r_col       <= '0;
                                r_dir       <= i_scroll_dir;
                                r_wr_row    <= i_scroll_dir ? w_prev_row : r_top_row;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + DIV_ONE;
                            end
                        end
                    end
                end
                S_WRITE_ROW: begin
                    if (r_col < COL_H) begin
                        r_bin_rd_en   <= 1'b1;
                        r_bin_rd_addr <= r_col[X_W-1:0];
                    end
                    if ((r_col != '0) && (r_col <= COL_H)) begin
                        r_fb_we   <= 1'b1;
                        r_row_wr  <= 1'b1;
                        r_fb_addr <= w_wr_addr;
                    end
                    if (r_col == COL_END) begin
                        r_row_done <= 1'b1;
                        r_top_row  <= w_next_top;
                    end else begin
                        r_col <= r_col + COL_ONE;
                    end
                end
                default: ;
            endcase
            if (i_clear_req) r_clear_pending <= 1'b1;
        end
    end

    assign o_bin_rd_en   = r_bin_rd_en;
    assign o_bin_rd_addr = r_bin_rd_addr;
    assign o_fb_addr     = r_fb_addr;
    assign o_fb_wdata    = r_row_wr ? i_bin_rd_data : '0;
    assign o_fb_we       = r_fb_we;
    assign o_top_row     = r_top_row;
    assign o_busy        = (r_state == S_CLEAR) || (r_state == S_WRITE_ROW);
    assign o_row_done    = r_row_done;
    assign o_dbg_state   = r_state;

endmodule
